lab2_proc_multi_drop_unit: RTL
==============================

Name: lab2_proc_multi_drop_unit

Overview:
Parametrised successor to the single-shot imem response drop unit. It sits between a memory response stream and the fetch stage. It tracks every outstanding request and, on a squash, discards the responses to all requests already in flight, however many there are. It also throttles new requests once p_max_inflight are outstanding. This allows deeper request queues (2+ in-flight fetches) with multi-cycle redirects.

Parameters:
p_msg_nbits, 47, response message width (mem_resp_4B_t)
p_max_inflight, 4, maximum outstanding requests; legal range 1..255
p_cnt_nbits, $clog2(p_max_inflight+1), counter width; derived, not overridden

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_fire  input  1  a request was accepted downstream this cycle (val && rdy at the memory request port)
req_allow  output  1  high when another request may be issued this cycle
squash  input  1  single-cycle pulse: discard responses to all requests accepted before this cycle
istream_msg  input  p_msg_nbits  response from memory
istream_val  input  1  response valid
istream_rdy  output  1  response ready
ostream_msg  output  p_msg_nbits  response to fetch stage
ostream_val  output  1  response valid
ostream_rdy  input  1  fetch stage ready
inflight_count  output  p_cnt_nbits  current outstanding request count (registered)
drop_count  output  p_cnt_nbits  outstanding responses still to discard (registered)

Behaviour:
- Reset (reset==0, asynchronous): inflight_cnt=0, drop_cnt=0, state=PASS. While reset is held: istream_rdy=0, ostream_val=0, req_allow=0. Outputs are valid from the first edge after deassertion.
- ostream_msg = istream_msg always (pure wire, zero latency).
- dropping = squash || (state==DROP).
- When dropping: ostream_val=0, istream_rdy=1.
- When not dropping: ostream_val=istream_val, istream_rdy=ostream_rdy.
- resp_fire = istream_val && istream_rdy.
- inflight_cnt_next = inflight_cnt + req_fire - resp_fire.
- drop_cnt_next:
  - If squash: inflight_cnt - resp_fire. Every outstanding request becomes to-drop, minus the one discarded this cycle.
  - Else if state==DROP and resp_fire: drop_cnt - 1.
  - Else: unchanged.
- A req_fire in the same cycle as squash is the new-path request. It is NOT dropped; it counts only in inflight_cnt.
- FSM, 2 states:
  - PASS -> DROP when drop_cnt_next != 0.
  - DROP -> PASS when drop_cnt_next == 0.
  - squash while in DROP reloads drop_cnt per the rule above; responses already counted are not double-counted.
  - Invariant: drop_cnt <= inflight_cnt.
- req_allow = (inflight_cnt < p_max_inflight) || resp_fire. This is a combinational path from istream_val and ostream_rdy; the fetch control must not feed req_allow back into ostream_rdy.
- Counter width: p_cnt_nbits is unsigned; all arithmetic is performed at p_cnt_nbits+1 and truncated.
- Protocol violations (simulation assertions, `ifndef SYNTHESIS):
  - req_fire with req_allow==0: inflight_cnt saturates at p_max_inflight.
  - istream_val with inflight_cnt==0 and !req_fire: the response passes through, inflight_cnt holds at 0 (no underflow).
  - squash asserted two consecutive cycles: legal; each squash recomputes drop_cnt.
- Full: inflight_cnt==p_max_inflight and no resp_fire -> req_allow=0.
- Empty: inflight_cnt==0 -> drop_cnt=0, state=PASS, and squash is a no-op.

Decomposition:
- Package lab2_proc_drop_pkg holds:
  - typedef enum logic {DROP_STATE_PASS, DROP_STATE_DROP} drop_state_t
  - localparam DROP_MAX_INFLIGHT_LIMIT = 255
- One sub-module, lab2_proc_updown_counter #(p_nbits, p_max): inc, dec, load, load_val, saturating at 0 and p_max. Instantiated twice:
  - inflight counter: load unused
  - drop counter: load=squash, dec=DROP && resp_fire

Test Plan:
- Passthrough: p_max_inflight=4; issue 3 reqs, then return 3 resps with data 0xA1, 0xA2, 0xA3 and ostream_rdy=1 -> all 3 appear on ostream in the same cycle they arrive; inflight_count goes 1, 2, 3 then back to 0; drop_count stays 0.
- Multi-drop: 3 reqs outstanding, squash with req_fire=1 in the same cycle -> drop_count=3, inflight_count=4; next 3 responses get istream_rdy=1 with ostream_val=0; the 4th response (0xB4) passes; final drop_count=0, state PASS.
- Squash coincident with response: 2 outstanding, squash while istream_val=1 (0xC1) -> 0xC1 dropped that cycle; drop_count=1 next cycle; following response 0xC2 dropped; inflight_count=0.
- Full/backpressure: 4 outstanding, no resp -> req_allow=0. A response arrives with ostream_rdy=1 -> req_allow=1 in the same cycle. With ostream_rdy=0 and a response present -> istream_rdy=0, req_allow=0.
- Back-to-back squash: 3 outstanding; squash, 1 drop, squash again -> drop_count 3, then 2, then reload to 2 (inflight-based); no response passes until inflight reaches 0.
- Async reset mid-drop: drop_count=2, pull reset low between clock edges -> counters clear immediately, istream_rdy=0; after release, an unexpected response passes through and the underflow assertion fires.

Source files
------------

// File: rtl/lab2_proc_drop_pkg.sv
// Shared types and limits for the multi-drop imem response unit.
package lab2_proc_drop_pkg;

  // PASS forwards responses to fetch; DROP silently consumes stale responses.
  typedef enum logic {
    DROP_STATE_PASS,
    DROP_STATE_DROP
  } drop_state_t;

  // Largest supported number of outstanding fetch requests.
  localparam int DROP_MAX_INFLIGHT_LIMIT = 255;

endpackage

// File: rtl/lab2_proc_updown_counter.sv
// Up/down counter with a parallel load, saturating at 0 and at p_max.
// Load takes priority over inc/dec; a simultaneous inc and dec cancel out.
module lab2_proc_updown_counter
  import lab2_proc_drop_pkg::*;
#(
  parameter int p_nbits = 3,
  parameter int p_max   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               load,
  input  logic [p_nbits-1:0] load_val,
  output logic [p_nbits-1:0] count,
  output logic [p_nbits-1:0] count_next
);

  localparam logic [p_nbits:0] MaxW = p_max[p_nbits:0];

  logic [p_nbits-1:0] count_q;
  logic [p_nbits-1:0] count_d;
  logic [p_nbits:0]   count_wide;
  logic [p_nbits:0]   load_wide;

  // Next count: load wins, otherwise a net step that clamps at both ends.
  always_comb begin
    count_d    = count_q;
    count_wide = {1'b0, count_q};
    load_wide  = {1'b0, load_val};
    if (load) begin
      count_d = (load_wide > MaxW) ? MaxW[p_nbits-1:0] : load_val;
    end else if (inc && !dec) begin
      if (count_wide < MaxW) begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/lab2_proc_multi_drop_unit.sv
// Tracks outstanding imem requests and, on a squash, discards the responses
// of every request already in flight; also throttles issue at p_max_inflight.
module lab2_proc_multi_drop_unit
  import lab2_proc_drop_pkg::*;
#(
  parameter int p_msg_nbits    = 47,
  parameter int p_max_inflight = 4,
  parameter int p_cnt_nbits    = $clog2(p_max_inflight + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_fire,
  output logic                   req_allow,
  input  logic                   squash,
  input  logic [p_msg_nbits-1:0] istream_msg,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_cnt_nbits-1:0] inflight_count,
  output logic [p_cnt_nbits-1:0] drop_count
);

  localparam logic [p_cnt_nbits:0] MaxInflightW = p_max_inflight[p_cnt_nbits:0];

  drop_state_t            state_q;
  drop_state_t            state_d;
  logic                   dropping;
  logic                   resp_fire;
  logic                   drop_dec;
  logic [p_cnt_nbits-1:0] inflight_cnt;
  logic [p_cnt_nbits-1:0] inflight_cnt_next;
  logic [p_cnt_nbits-1:0] drop_cnt;
  logic [p_cnt_nbits-1:0] drop_cnt_next;
  logic [p_cnt_nbits:0]   drop_load_wide;
  logic [p_cnt_nbits-1:0] drop_load_val;

  // The message path is a plain wire; only valid/ready are steered.
  assign ostream_msg = istream_msg;

  // Handshake steering: while dropping, swallow responses; otherwise pass through.
  always_comb begin
    dropping    = squash || (state_q == DROP_STATE_DROP);
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    if (reset) begin
      if (dropping) begin
        istream_rdy = 1'b1;
      end else begin
        istream_rdy = ostream_rdy;
        ostream_val = istream_val;
      end
    end
    resp_fire = istream_val && istream_rdy;
  end

  // Issue throttle: a response retiring this cycle frees a slot immediately.
  always_comb begin
    req_allow = reset && (({1'b0, inflight_cnt} < MaxInflightW) || resp_fire);
  end

  // Squash reload: everything outstanding becomes stale, minus a response consumed now.
  always_comb begin
    drop_load_wide = {1'b0, inflight_cnt} - {{p_cnt_nbits{1'b0}}, resp_fire};
    drop_load_val  = drop_load_wide[p_cnt_nbits] ? '0 : drop_load_wide[p_cnt_nbits-1:0];
    drop_dec       = (state_q == DROP_STATE_DROP) && resp_fire;
  end

  lab2_proc_updown_counter #(
    .p_nbits (p_cnt_nbits),
    .p_max   (p_max_inflight)
  ) u_inflight_counter (
    .clk        (clk),
    .reset      (reset),
    .inc        (req_fire),
    .dec        (resp_fire),
    .load       (1'b0),
    .load_val   ('0),
    .count      (inflight_cnt),
    .count_next (inflight_cnt_next)
  );

  lab2_proc_updown_counter #(
    .p_nbits (p_cnt_nbits),
    .p_max   (p_max_inflight)
  ) u_drop_counter (
    .clk        (clk),
    .reset      (reset),
    .inc        (1'b0),
    .dec        (drop_dec),
    .load       (squash),
    .load_val   (drop_load_val),
    .count      (drop_cnt),
    .count_next (drop_cnt_next)
  );

  // Stay in DROP exactly while stale responses remain to be consumed.
  always_comb begin
    state_d = (drop_cnt_next != '0) ? DROP_STATE_DROP : DROP_STATE_PASS;
  end

  // State register, returns to PASS on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DROP_STATE_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  assign inflight_count = inflight_cnt;
  assign drop_count     = drop_cnt;

`ifndef SYNTHESIS
  // Flag misuse by the surrounding fetch logic; the counters clamp regardless.
  always @(posedge clk) begin
    if (reset) begin
      if (p_max_inflight < 1 || p_max_inflight > DROP_MAX_INFLIGHT_LIMIT)
        $warning("drop unit: p_max_inflight %0d outside 1..%0d",
                 p_max_inflight, DROP_MAX_INFLIGHT_LIMIT);
      if (req_fire && !req_allow)
        $warning("drop unit: request issued while throttled, inflight count clamps");
      if (istream_val && (inflight_cnt == '0) && !req_fire)
        $warning("drop unit: response with no outstanding request, inflight count holds at 0");
    end
  end
`endif

endmodule
